mem_access_unit: RTL

Load/store unit between the multicycle core's datapath and the word-wide BRAM memory port. It accepts one byte, halfword or word request at a time and drives a word-aligned address, byte-lane mask and lane-replicated write data to memory. For loads it absorbs the BRAM's one-cycle synchronous read latency, then extracts and zero- or sign-extends the addressed lanes. It returns a single-cycle response with an optional fault flag.

---
 rtl/mem_access_pkg.sv | 58 +++++
 rtl/load_formatter.sv | 32 +++
 rtl/mem_access_unit.sv | 124 ++++++++++++
 3 files changed

// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared types and helpers for the load/store unit
// Purpose: FSM state enum, RV32I load/store width codes, and the pure helper
//          functions for legality, alignment, byte-lane mask and lane data.
// Ports:   none (package).
package mem_access_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Access size is encoded in funct3[1:0] for every legal code.
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;

    // Unsigned widths only exist for loads.
    function automatic logic width_legal(input logic write, input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_H, F3_W: return 1'b1;
            F3_BU, F3_HU:     return !write;
            default:          return 1'b0;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return addr_lo[0];
            default: return addr_lo != 2'b00;
        endcase
    endfunction

    // Halfwords look at addr[1] only, so a stray addr[0] cannot split lanes.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_B:    return 4'b0001 << addr_lo;
            SZ_H:    return 4'b0011 << {addr_lo[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            SZ_B:    return {4{wdata[7:0]}};
            SZ_H:    return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

endpackage

// File: rtl/load_formatter.sv
// rtl/load_formatter.sv - combinational extraction and extension of load data
// Purpose: select the addressed byte/halfword of the read word and zero- or
//          sign-extend it; words pass through.
// Ports:   rdata_i (raw memory word), addr_lo_i (byte offset), funct3_i (width
//          code), result_o (formatted 32-bit load value).
module load_formatter
    import mem_access_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] result_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = rdata_i[{addr_lo_i, 3'b000} +: 8];
    assign half_sel = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];

    always_comb begin
        result_o = rdata_i;
        case (funct3_i)
            F3_B:    result_o = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   result_o = {24'd0, byte_sel};
            F3_H:    result_o = {{16{half_sel[15]}}, half_sel};
            F3_HU:   result_o = {16'd0, half_sel};
            default: result_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store unit between core datapath and BRAM port
// Purpose: one request at a time; drives word address, lane mask and
//          replicated store data, absorbs the one-cycle BRAM read latency and
//          returns a single-cycle response with a fault flag.
// Ports:   clk, rst_n (async active-low); req_* request handshake and fields;
//          rsp_valid/rsp_rdata/rsp_fault response pulse; memAddress,
//          memWriteData, memWrite, byteMask to memory; memReadData from memory.
// Config:  MEM_ACCESS_MISALIGN_TRAP_EN - misaligned H/W requests fault instead
//          of ignoring the low address bits.
module mem_access_unit
    import mem_access_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault,
    output logic [31:0] memAddress,
    output logic [31:0] memWriteData,
    output logic        memWrite,
    output logic [3:0]  byteMask,
    input  logic [31:0] memReadData
);

    state_e      state_q, state_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic [2:0]  f3_q, f3_d;
    logic        write_q, write_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        fault_q, fault_d;
    logic [31:0] fmt_result;
    logic        misalign;

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    assign misalign = is_misaligned(req_funct3[1:0], req_addr[1:0]);
`else
    assign misalign = 1'b0;
`endif

    load_formatter u_fmt (
        .rdata_i   (memReadData),
        .addr_lo_i (addr_lo_q),
        .funct3_i  (f3_q),
        .result_o  (fmt_result)
    );

    always_comb begin
        state_d     = state_q;
        addr_lo_d   = addr_lo_q;
        f3_d        = f3_q;
        write_d     = write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        fault_d     = fault_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_lo_d = req_addr[1:0];
                    f3_d      = req_funct3;
                    write_d   = req_write;
                    rdata_d   = 32'd0;
                    if (!width_legal(req_write, req_funct3) || misalign) begin
                        // Faulting requests never touch the memory port.
                        fault_d = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        fault_d     = 1'b0;
                        mem_addr_d  = {req_addr[31:2], 2'b00};
                        mem_wdata_d = lane_data(req_funct3[1:0], req_wdata);
                        state_d     = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS:  state_d = write_q ? ST_RESP : ST_CAPTURE;
            ST_CAPTURE: begin
                rdata_d = fmt_result;
                state_d = ST_RESP;
            end
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            addr_lo_q   <= 2'b00;
            f3_q        <= 3'b000;
            write_q     <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            rdata_q     <= 32'd0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_lo_q   <= addr_lo_d;
            f3_q        <= f3_d;
            write_q     <= write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            fault_q     <= fault_d;
        end
    end

    // Strobe and mask decode straight from state so reset kills them at once.
    assign req_ready    = (state_q == ST_IDLE);
    assign rsp_valid    = (state_q == ST_RESP);
    assign rsp_rdata    = rdata_q;
    assign rsp_fault    = fault_q;
    assign memAddress   = mem_addr_q;
    assign memWriteData = mem_wdata_q;
    assign memWrite     = (state_q == ST_ACCESS) && write_q;
    assign byteMask     = (state_q == ST_ACCESS) ? lane_mask(f3_q[1:0], addr_lo_q) : 4'b0000;

endmodule
